// File: rtl/r5fp_sb_pkg.sv
// Purpose: shared types and FP-aware compare helpers for the R5FP result scoreboard.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
// Contents: scoreboard state enum, is_zero / is_nan classifiers and the
// results_match rule. Helpers take the format widths as arguments and operate
// on words zero-extended to MAX_W bits, so any EXP_W/SIG_W up to MAX_W works.
package r5fp_sb_pkg;

  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2,
    HALT  = 2'd3
  } sb_state_e;

  // Low w bits set.
  function automatic logic [MAX_W-1:0] field_mask(input int unsigned w);
    return (MAX_W'(1) << w) - MAX_W'(1);
  endfunction

  // Exponent and significand both zero; the sign bit is ignored.
  function automatic logic is_zero(input logic [MAX_W-1:0] z,
                                   input int unsigned exp_w,
                                   input int unsigned sig_w);
    logic [MAX_W-1:0] mag;
    mag = z & field_mask(exp_w + sig_w);
    return (mag == '0);
  endfunction

  // Exponent all ones with a non-zero significand; payload and sign ignored.
  function automatic logic is_nan(input logic [MAX_W-1:0] z,
                                  input int unsigned exp_w,
                                  input int unsigned sig_w);
    logic [MAX_W-1:0] e;
    logic [MAX_W-1:0] s;
    e = (z >> sig_w) & field_mask(exp_w);
    s = z & field_mask(sig_w);
    return (e == field_mask(exp_w)) && (s != '0);
  endfunction

  // Values are equivalent when bit-identical, both zero, or both NaN.
  // Status flags must always agree exactly.
  function automatic logic results_match(input logic [MAX_W-1:0] exp_z,
                                         input logic [MAX_W-1:0] dut_z,
                                         input logic [7:0]       exp_st,
                                         input logic [7:0]       dut_st,
                                         input int unsigned      exp_w,
                                         input int unsigned      sig_w);
    logic val_ok;
    val_ok = (exp_z == dut_z)
          || (is_zero(exp_z, exp_w, sig_w) && is_zero(dut_z, exp_w, sig_w))
          || (is_nan(exp_z, exp_w, sig_w) && is_nan(dut_z, exp_w, sig_w));
    return val_ok && (exp_st == dut_st);
  endfunction

endpackage

// File: rtl/r5fp_sb_fifo.sv
// Purpose: synchronous FIFO holding golden entries awaiting a DUT result.
// Latency: head visible the cycle after push; head_dat is a combinational read.
// Backpressure: push ignored when full, pop ignored when empty.
// Ports: clk, reset (sync, active-high); push/push_dat write side;
// pop/head_dat read side; full/empty status flags.
module r5fp_sb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign head_dat = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only read while counted as valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat;
  end

endmodule

// File: rtl/r5fp_result_scoreboard.sv
// Purpose: in-order checker pairing golden FP results with later DUT results.
// Latency: compare registered; counters/mismatch/capture update 1 cycle after dut_valid.
// Backpressure: exp_ready drops when the FIFO is full or once draining; DUT side has none.
// Ports: exp_* golden entry (valid/ready), dut_* result stream (valid only),
// flush ends stimulus; pass_cnt/fail_cnt, mismatch pulse, first_fail_* capture,
// sticky orphan_err/timeout_err, done in DONE or HALT.
module r5fp_result_scoreboard #(
  parameter int EXP_W        = 5,
  parameter int SIG_W        = 6,
  parameter int DEPTH        = 16,
  parameter int CNT_W        = 32,
  parameter int TIMEOUT      = 1024,
  parameter int STOP_ON_FAIL = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   exp_valid,
  output logic                   exp_ready,
  input  logic [EXP_W+SIG_W:0]   exp_a,
  input  logic [EXP_W+SIG_W:0]   exp_b,
  input  logic [EXP_W+SIG_W:0]   exp_z,
  input  logic [7:0]             exp_status,
  input  logic                   dut_valid,
  input  logic [EXP_W+SIG_W:0]   dut_z,
  input  logic [7:0]             dut_status,
  input  logic                   flush,
  output logic [CNT_W-1:0]       pass_cnt,
  output logic [CNT_W-1:0]       fail_cnt,
  output logic                   mismatch,
  output logic                   first_fail_valid,
  output logic [EXP_W+SIG_W:0]   first_fail_a,
  output logic [EXP_W+SIG_W:0]   first_fail_b,
  output logic [EXP_W+SIG_W:0]   first_fail_exp,
  output logic [EXP_W+SIG_W:0]   first_fail_dut,
  output logic                   orphan_err,
  output logic                   timeout_err,
  output logic                   done
);

  import r5fp_sb_pkg::*;

  localparam int   W    = EXP_W + SIG_W + 1;
  localparam int   EW   = 4*W + 8;
  localparam int   TW   = $clog2(TIMEOUT + 1);
  localparam logic STOP = (STOP_ON_FAIL != 0);

  // FIFO entry layout, MSB first: a | b | z | spare lane (zero) | status.
  logic [EW-1:0]  push_dat, head_dat;
  logic [W-1:0]   head_a, head_b, head_z, head_rsvd;
  logic [7:0]     head_st;
  logic           fifo_full, fifo_empty;
  logic           unused_rsvd;

  logic           active, do_push, do_pop, orphan, cmp_ok;
  logic           fail_now, pass_now, stall_hit, stop;

  sb_state_e      state_q, state_d;
  logic [TW-1:0]  stall_q, stall_d;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic           mismatch_q, mismatch_d;
  logic           ff_vld_q, ff_vld_d;
  logic [W-1:0]   ff_a_q, ff_a_d, ff_b_q, ff_b_d;
  logic [W-1:0]   ff_exp_q, ff_exp_d, ff_dut_q, ff_dut_d;
  logic           orphan_err_q, orphan_err_d;
  logic           timeout_err_q, timeout_err_d;
  logic           done_q, done_d;

  assign push_dat = {exp_a, exp_b, exp_z, {W{1'b0}}, exp_status};
  assign head_a    = head_dat[4*W+7 -: W];
  assign head_b    = head_dat[3*W+7 -: W];
  assign head_z    = head_dat[2*W+7 -: W];
  assign head_rsvd = head_dat[W+7 -: W];
  assign head_st   = head_dat[7:0];
  assign unused_rsvd = ^head_rsvd;

  r5fp_sb_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (do_push),
    .push_dat (push_dat),
    .pop      (do_pop),
    .head_dat (head_dat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Inputs are only honoured in RUN/DRAIN; DONE and HALT freeze everything.
  assign active    = (state_q == RUN) || (state_q == DRAIN);
  assign exp_ready = !reset && !fifo_full && (state_q == RUN);
  assign do_push   = exp_valid && exp_ready;
  // A result arriving with an empty FIFO cannot pair with a same-cycle push:
  // the push only becomes the head on the next cycle.
  assign do_pop    = active && dut_valid && !fifo_empty;
  assign orphan    = active && dut_valid && fifo_empty;

  assign cmp_ok   = results_match(MAX_W'(head_z), MAX_W'(dut_z), head_st, dut_status,
                                  EXP_W, SIG_W);
  assign pass_now = do_pop && cmp_ok;
  assign fail_now = orphan || (do_pop && !cmp_ok);

  // Stall counter: waiting cycles with work outstanding and nothing returned.
  assign stall_hit = active && !fifo_empty && !dut_valid && (stall_q == TW'(TIMEOUT - 1));

  always_comb begin
    stall_d = stall_q;
    if (active) begin
      if (!fifo_empty && !dut_valid) stall_d = stall_q + 1'b1;
      else                           stall_d = '0;
    end
  end

  assign stop = (fail_now && STOP) || stall_hit;

  // Drain completes once nothing is queued and no result is being checked
  // this cycle; the last compare has already landed at the popping edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (stop)       state_d = HALT;
        else if (flush) state_d = DRAIN;
      end
      DRAIN: begin
        if (stop)                          state_d = HALT;
        else if (fifo_empty && !dut_valid) state_d = DONE;
      end
      default: state_d = state_q;
    endcase
  end

  always_comb begin
    pass_cnt_d    = pass_cnt_q;
    fail_cnt_d    = fail_cnt_q;
    mismatch_d    = fail_now;
    ff_vld_d      = ff_vld_q;
    ff_a_d        = ff_a_q;
    ff_b_d        = ff_b_q;
    ff_exp_d      = ff_exp_q;
    ff_dut_d      = ff_dut_q;
    orphan_err_d  = orphan_err_q || orphan;
    timeout_err_d = timeout_err_q || stall_hit;
    done_d        = (state_d == DONE) || (state_d == HALT);

    // Counters saturate rather than wrap.
    if (pass_now && (pass_cnt_q != {CNT_W{1'b1}})) pass_cnt_d = pass_cnt_q + 1'b1;
    if (fail_now && (fail_cnt_q != {CNT_W{1'b1}})) fail_cnt_d = fail_cnt_q + 1'b1;

    // Orphans have no golden entry, so the golden side of the capture is zero.
    if (fail_now && !ff_vld_q) begin
      ff_vld_d = 1'b1;
      ff_a_d   = orphan ? '0 : head_a;
      ff_b_d   = orphan ? '0 : head_b;
      ff_exp_d = orphan ? '0 : head_z;
      ff_dut_d = dut_z;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      stall_q       <= '0;
      pass_cnt_q    <= '0;
      fail_cnt_q    <= '0;
      mismatch_q    <= 1'b0;
      ff_vld_q      <= 1'b0;
      ff_a_q        <= '0;
      ff_b_q        <= '0;
      ff_exp_q      <= '0;
      ff_dut_q      <= '0;
      orphan_err_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      stall_q       <= stall_d;
      pass_cnt_q    <= pass_cnt_d;
      fail_cnt_q    <= fail_cnt_d;
      mismatch_q    <= mismatch_d;
      ff_vld_q      <= ff_vld_d;
      ff_a_q        <= ff_a_d;
      ff_b_q        <= ff_b_d;
      ff_exp_q      <= ff_exp_d;
      ff_dut_q      <= ff_dut_d;
      orphan_err_q  <= orphan_err_d;
      timeout_err_q <= timeout_err_d;
      done_q        <= done_d;
    end
  end

  assign pass_cnt         = pass_cnt_q;
  assign fail_cnt         = fail_cnt_q;
  assign mismatch         = mismatch_q;
  assign first_fail_valid = ff_vld_q;
  assign first_fail_a     = ff_a_q;
  assign first_fail_b     = ff_b_q;
  assign first_fail_exp   = ff_exp_q;
  assign first_fail_dut   = ff_dut_q;
  assign orphan_err       = orphan_err_q;
  assign timeout_err      = timeout_err_q;
  assign done             = done_q;

endmodule

// File: tb/tb_r5fp_result_scoreboard.sv
// Purpose: randomized self-checking bench for r5fp_result_scoreboard (default parameters).
// Latency: reference model advances on each rising edge; outputs compared 1 time unit later.
// Backpressure: stimulus only offers pushes the reference model says will be accepted.
module tb_r5fp_result_scoreboard;

  localparam int W       = 12;
  localparam int QDEPTH  = 16;
  localparam int TIMEOUT = 1024;

  logic         clk = 1'b0;
  logic         reset;
  logic         exp_valid, exp_ready;
  logic [W-1:0] exp_a, exp_b, exp_z;
  logic [7:0]   exp_status;
  logic         dut_valid;
  logic [W-1:0] dut_z;
  logic [7:0]   dut_status;
  logic         flush;
  logic [31:0]  pass_cnt, fail_cnt;
  logic         mismatch, first_fail_valid, orphan_err, timeout_err, done;
  logic [W-1:0] first_fail_a, first_fail_b, first_fail_exp, first_fail_dut;

  always #5 clk = ~clk;

  r5fp_result_scoreboard #(
    .EXP_W(5), .SIG_W(6), .DEPTH(16), .CNT_W(32), .TIMEOUT(1024), .STOP_ON_FAIL(1)
  ) dut (
    .clk(clk), .reset(reset),
    .exp_valid(exp_valid), .exp_ready(exp_ready),
    .exp_a(exp_a), .exp_b(exp_b), .exp_z(exp_z), .exp_status(exp_status),
    .dut_valid(dut_valid), .dut_z(dut_z), .dut_status(dut_status),
    .flush(flush),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .mismatch(mismatch),
    .first_fail_valid(first_fail_valid),
    .first_fail_a(first_fail_a), .first_fail_b(first_fail_b),
    .first_fail_exp(first_fail_exp), .first_fail_dut(first_fail_dut),
    .orphan_err(orphan_err), .timeout_err(timeout_err), .done(done)
  );

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] z;
    logic [7:0]   st;
  } ent_t;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: queue of outstanding golden entries plus observable results.
  ent_t         m_q[$];
  int           m_pass, m_fail, m_stall;
  bit           m_mm, m_ffv, m_orph, m_tout, m_drain, m_fin, m_halt;
  logic [W-1:0] m_ffa, m_ffb, m_ffe, m_ffd;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic bit f_zero(input logic [W-1:0] z);
    int v;
    v = int'(z);
    return ((v / 64) % 32 == 0) && (v % 64 == 0);
  endfunction

  function automatic bit f_nan(input logic [W-1:0] z);
    int v;
    v = int'(z);
    return ((v / 64) % 32 == 31) && (v % 64 != 0);
  endfunction

  function automatic bit f_match(input ent_t e, input logic [W-1:0] z, input logic [7:0] st);
    bit same;
    same = (e.z == z) || (f_zero(e.z) && f_zero(z)) || (f_nan(e.z) && f_nan(z));
    return same && (e.st == st);
  endfunction

  function automatic bit m_ready();
    return !reset && !m_drain && !m_fin && !m_halt && (m_q.size() < QDEPTH);
  endfunction

  task automatic model_clear();
    m_q.delete();
    m_pass = 0; m_fail = 0; m_stall = 0;
    m_mm = 0; m_ffv = 0; m_orph = 0; m_tout = 0;
    m_drain = 0; m_fin = 0; m_halt = 0;
    m_ffa = '0; m_ffb = '0; m_ffe = '0; m_ffd = '0;
  endtask

  // One clock edge of the scoreboard's contract, applied to the current inputs.
  task automatic model_edge();
    bit   was_ready, fail, orph;
    int   occ;
    ent_t h;
    m_mm = 0;
    if (reset) begin
      model_clear();
      return;
    end
    if (m_halt || m_fin) return;
    was_ready = m_ready();
    occ  = m_q.size();
    fail = 0;
    orph = 0;
    h    = '0;
    if (dut_valid) begin
      if (occ == 0) begin
        orph = 1;
        fail = 1;
      end else begin
        h = m_q.pop_front();
        if (f_match(h, dut_z, dut_status)) m_pass++;
        else fail = 1;
      end
    end
    if (exp_valid && was_ready) m_q.push_back('{a: exp_a, b: exp_b, z: exp_z, st: exp_status});
    if (fail) begin
      m_fail++;
      m_mm = 1;
      if (orph) m_orph = 1;
      if (!m_ffv) begin
        m_ffv = 1;
        m_ffa = h.a; m_ffb = h.b; m_ffe = h.z; m_ffd = dut_z;
      end
    end
    if (occ > 0 && !dut_valid) m_stall++;
    else                       m_stall = 0;
    if (m_stall == TIMEOUT) m_tout = 1;
    if (fail || m_stall == TIMEOUT)       m_halt = 1;
    else if (!m_drain && flush)           m_drain = 1;
    else if (m_drain && occ == 0 && !dut_valid) m_fin = 1;
  endtask

  task automatic compare_all();
    chk("exp_ready", exp_ready, m_ready());
    chk("pass_cnt", pass_cnt, 64'(m_pass));
    chk("fail_cnt", fail_cnt, 64'(m_fail));
    chk("mismatch", mismatch, m_mm);
    chk("ff_valid", first_fail_valid, m_ffv);
    chk("ff_a", first_fail_a, m_ffa);
    chk("ff_b", first_fail_b, m_ffb);
    chk("ff_exp", first_fail_exp, m_ffe);
    chk("ff_dut", first_fail_dut, m_ffd);
    chk("orphan_err", orphan_err, m_orph);
    chk("timeout_err", timeout_err, m_tout);
    chk("done", done, m_halt || m_fin);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    cyc++;
  endtask

  task automatic idle();
    exp_valid = 0; exp_a = '0; exp_b = '0; exp_z = '0; exp_status = '0;
    dut_valid = 0; dut_z = '0; dut_status = '0; flush = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    idle();
    repeat (2) step();
    reset = 0;
  endtask

  function automatic logic [W-1:0] gen_z();
    logic [W-1:0] z;
    int k;
    z = W'($urandom);
    k = $urandom_range(0, 5);
    case (k)
      0: z = {z[W-1], 11'h000};
      1: z = {z[W-1], 5'h1F, (z[5:0] == 6'd0) ? 6'd1 : z[5:0]};
      2: z = {z[W-1], 11'h7C0};
      default: z = z;
    endcase
    return z;
  endfunction

  // A different encoding the rules treat as equal (other zero sign, other NaN).
  function automatic logic [W-1:0] equiv(input logic [W-1:0] z);
    logic [W-1:0] r;
    r = z;
    if (f_zero(z)) r = {1'($urandom), 11'h000};
    else if (f_nan(z)) begin
      r = W'($urandom);
      r = {r[W-1], 5'h1F, (r[5:0] == 6'd0) ? 6'd2 : r[5:0]};
    end
    return r;
  endfunction

  task automatic push_one(input logic [W-1:0] z, input logic [7:0] st);
    exp_valid = 1; exp_a = W'($urandom); exp_b = W'($urandom); exp_z = z; exp_status = st;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   k, last_cyc;
    ent_t sent[$];
    ent_t t;
    logic [W-1:0] zz;

    model_clear();
    do_reset();

    // Single matching result, 3 cycles after the push.
    push_one(12'h3C0, 8'h00); step(); idle();
    step(); step();
    dut_valid = 1; dut_z = 12'h3C0; dut_status = 8'h00; step(); idle(); step();
    chk("t1_pass", pass_cnt, 1);
    chk("t1_fail", fail_cnt, 0);

    // NaN-vs-NaN and +0 vs -0 are both passes.
    do_reset();
    push_one(12'h7C1, 8'h00); step();
    push_one(12'h000, 8'h00); step(); idle();
    dut_valid = 1; dut_z = 12'h7E0; step();
    dut_z = 12'h800; step(); idle(); step();
    chk("t2_pass", pass_cnt, 2);
    chk("t2_fail", fail_cnt, 0);

    // Status mismatch with equal value halts.
    do_reset();
    push_one(12'h3C0, 8'h00); step(); idle();
    dut_valid = 1; dut_z = 12'h3C0; dut_status = 8'h20; step(); idle();
    chk("t3_mismatch", mismatch, 1);
    chk("t3_ff_exp", first_fail_exp, 12'h3C0);
    chk("t3_done", done, 1);
    push_one(12'h123, 8'h00); step(); idle();
    chk("t3_ready_halt", exp_ready, 0);
    chk("t3_fail", fail_cnt, 1);

    // Fill the FIFO, then stall until the timeout fires.
    do_reset();
    k = 0;
    for (int i = 0; i < QDEPTH; i++) begin
      push_one(gen_z(), 8'h00); step(); k++;
    end
    chk("t4_full_ready", exp_ready, 0);
    repeat (5) begin push_one(gen_z(), 8'h00); step(); k++; end
    idle();
    while (!timeout_err && k < 1200) begin step(); k++; end
    chk("t4_timeout_cycle", 64'(k), 64'(TIMEOUT + 1));
    chk("t4_timeout", timeout_err, 1);

    // Orphan right after reset, then orphan alongside the first push.
    do_reset();
    dut_valid = 1; dut_z = 12'h555; step(); idle();
    chk("t5_orphan", orphan_err, 1);
    chk("t5_ff_exp", first_fail_exp, 0);
    do_reset();
    push_one(12'h3C0, 8'h00); dut_valid = 1; dut_z = 12'h3C0; step(); idle();
    chk("t5b_orphan", orphan_err, 1);

    // Flush then drain with gapped results; done one cycle after the last compare.
    do_reset();
    sent.delete();
    for (int i = 0; i < 4; i++) begin
      push_one(gen_z(), 8'(i)); step();
      sent.push_back('{a: exp_a, b: exp_b, z: exp_z, st: exp_status});
    end
    idle(); flush = 1; step(); flush = 0;
    last_cyc = 0;
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 5)) step();
      t = sent.pop_front();
      dut_valid = 1; dut_z = equiv(t.z); dut_status = t.st; step(); idle();
      last_cyc = cyc;
    end
    chk("t6_pass", pass_cnt, 4);
    k = 0;
    while (!done && k < 20) begin step(); k++; end
    chk("t6_done_lat", 64'(cyc - last_cyc), 1);

    // Randomized episodes; every third one injects corrupt or orphan results.
    for (int ep = 0; ep < 12; ep++) begin
      int  n, pushed;
      bit  bad, acc;
      do_reset();
      sent.delete();
      n = $urandom_range(5, 40);
      pushed = 0;
      bad = (ep % 3 == 2);
      k = 0;
      while (!done && k < 600) begin
        idle();
        acc = 0;
        if (pushed < n && $urandom_range(0, 3) != 0) begin
          push_one(gen_z(), ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00);
          acc = m_ready();
        end else if (pushed >= n && !m_drain) begin
          flush = 1;
        end
        if (sent.size() > 0 && $urandom_range(0, 2) != 0) begin
          t = sent.pop_front();
          zz = equiv(t.z);
          dut_valid = 1; dut_z = zz; dut_status = t.st;
          if (bad && $urandom_range(0, 19) == 0) begin
            if ($urandom_range(0, 1) == 0) dut_z = zz ^ (W'(1) << $urandom_range(0, W-1));
            else dut_status = t.st ^ 8'h01;
          end
        end else if (bad && sent.size() == 0 && $urandom_range(0, 24) == 0) begin
          dut_valid = 1; dut_z = W'($urandom);
        end
        step();
        if (acc) begin
          sent.push_back('{a: exp_a, b: exp_b, z: exp_z, st: exp_status});
          pushed++;
        end
        k++;
      end
      chk("ep_done", done, 1);
    end

    idle();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
